banked_ram_stream_reader: RTL and testbench
===========================================

Name: banked_ram_stream_reader

Overview:
- Read-side initiator for the scratchpad banked RAM read port.
- Given a base address, stride and word count, it issues one read request per cycle to the RAM.
- Captures the returned data under the RAM's fixed 1-cycle read latency.
- Delivers words in order on a valid/ready stream, with credit-based backpressure so no returned word is ever dropped.

Parameters:
- ADDR_WIDTH, 13, RAM word address width (tag + local address).
- DATA_WIDTH, 16, RAM word width.
- COUNT_W, 16, width of the word-count field.
- FIFO_ADDR_W, 2, log2 of the output buffer depth. Depth = 1<<FIFO_ADDR_W; must be >= 2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- cfg_start  input  1  single-cycle pulse that launches a transfer.
- cfg_base_addr  input  ADDR_WIDTH  first word address.
- cfg_stride  input  ADDR_WIDTH  address increment per word.
- cfg_num_words  input  COUNT_W  number of words to read.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when the transfer completes.
- mem_read_req  output  1  read request to the RAM.
- mem_read_addr  output  ADDR_WIDTH  read address.
- mem_read_data  input  DATA_WIDTH  RAM data, valid the cycle after mem_read_req.
- m_data  output  DATA_WIDTH  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready.

Behaviour:
- Reset values: busy=0, done=0, mem_read_req=0, mem_read_addr=0, m_valid=0, m_data=0. Buffer empty, in-flight flag clear, state IDLE.
- State IDLE:
  - cfg_start latches base, stride and count; go to ISSUE (busy=1 next cycle).
  - If cfg_num_words=0: no reads issued, done pulses the cycle after start, state stays IDLE.
- State ISSUE:
  - mem_read_req=1 whenever issued_remaining>0 and (buffer occupancy + in-flight) < depth.
  - mem_read_addr is combinational from the address register.
  - Address register advances by cfg_stride on each request, modulo 2^ADDR_WIDTH (wrap-around, carry discarded).
  - When the last request issues, go to DRAIN.
- State DRAIN:
  - Wait until the in-flight read has landed and the buffer is empty.
  - done pulses in the cycle after the final m_valid&&m_ready handshake; busy drops in that same cycle; return to IDLE.
- Read capture: a 1-bit in-flight register is set by mem_read_req. On the next cycle mem_read_data is written into the buffer unconditionally; the credit rule guarantees space.
- Stream side:
  - m_valid = buffer not empty; m_data = buffer head.
  - Word pops on m_valid&&m_ready.
  - A simultaneous push and pop on a full buffer is legal.
- Throughput: 1 word/cycle sustained with m_ready held high.
- Latency: cfg_start to first m_valid is 3 cycles (start latch, request, capture).
- cfg_start while busy=1 is ignored; the running transfer continues unaffected.
- Reset mid-transfer: returns to IDLE next cycle, buffer flushed, no done pulse, any in-flight RAM data discarded.
- The count register is COUNT_W wide. The maximum count 2^COUNT_W-1 is supported.

Optional Feature:
- Macro STREAM_READER_STATS_EN.
- Defined:
  - Adds output port stall_cycles, width 32.
  - Counts cycles with busy=1 && m_valid=1 && m_ready=0.
  - Cleared on reset and on an accepted cfg_start; saturates at all-ones.
- Undefined: port and counter absent. Functional behaviour is identical either way.

Decomposition:
- Shared package stream_reader_pkg:
  - State encoding constants STATE_IDLE=0, STATE_ISSUE=1, STATE_DRAIN=2, state width 2.
  - MEM_READ_LATENCY=1.
- One sub-module: stream_reader_fifo.
  - Synchronous FIFO, parameters DATA_WIDTH and FIFO_ADDR_W.
  - Ports: push, push_data, pop, head_data, empty, full, count.
  - Count is FIFO_ADDR_W+1 bits.
- Top level holds the FSM, address and count registers, credit logic and the in-flight flag.

Test Plan:
- Basic read:
  - Stimulus: RAM preloaded with mem[k]=k; base=0x0010, stride=1, num=4, m_ready=1.
  - Required: mem_read_addr 0x10..0x13 on consecutive cycles; m_data 0x10, 0x11, 0x12, 0x13 back-to-back, first valid 3 cycles after start; single done pulse.
- Stride and wrap:
  - Stimulus: base=0x1FFE, stride=0x0800, num=3.
  - Required: addresses 0x1FFE, 0x07FE, 0x0FFE; data in order.
- Backpressure:
  - Stimulus: num=10, depth=4, m_ready low for cycles 4..12.
  - Required: requests stall once occupancy+in-flight=4; no word lost or duplicated; all 10 words in order; done after the 10th handshake.
- Zero count and start-while-busy:
  - Stimulus: num=0; then a second cfg_start during a 6-word transfer.
  - Required: done 1 cycle after the zero-count start with no mem_read_req; the second start is ignored and exactly 6 words are delivered.
- Reset mid-transfer:
  - Stimulus: assert reset for 1 cycle after 2 of 8 words have been delivered.
  - Required: all outputs at reset values the next cycle; no done pulse; a new start with num=2 delivers exactly 2 fresh words.
- Stats (STREAM_READER_STATS_EN):
  - Stimulus: m_ready low for 5 cycles while m_valid=1.
  - Required: stall_cycles=5; cleared on the next accepted start.

Source files
------------

// File: rtl/banked_ram_stream_reader_pkg.sv
// Shared types for the banked RAM stream reader.
// FSM state encoding and the RAM read latency.
package stream_reader_pkg;

    localparam int STATE_W          = 2;
    localparam int MEM_READ_LATENCY = 1;

    typedef enum logic [STATE_W-1:0] {
        STATE_IDLE  = 2'd0,
        STATE_ISSUE = 2'd1,
        STATE_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/banked_ram_stream_reader_if.sv
// RAM read port and output stream of the stream reader.
// master = reader side, slave = RAM/consumer side.
interface banked_ram_stream_reader_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16
);

    logic                  mem_read_req;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output mem_read_req,
        output mem_read_addr,
        input  mem_read_data,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  mem_read_req,
        input  mem_read_addr,
        output mem_read_data,
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/stream_reader_fifo.sv
// Small synchronous FIFO buffering RAM read data.
// Push and pop in the same cycle are legal even when full.
module stream_reader_fifo #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  empty,
    output logic                  full,
    output logic [FIFO_ADDR_W:0]  count
);

    localparam int DEPTH = 1 << FIFO_ADDR_W;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr;
    logic [FIFO_ADDR_W-1:0] rd_ptr;
    logic                   do_pop;

    assign do_pop    = pop && !empty;
    assign empty     = (count == '0);
    assign full      = (count == (FIFO_ADDR_W+1)'(DEPTH));
    assign head_data = mem[rd_ptr];

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + (FIFO_ADDR_W+1)'(1);
                2'b01:   count <= count - (FIFO_ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/banked_ram_stream_reader.sv
// Strided RAM reader feeding a valid/ready stream with credit flow control.
// Optional STREAM_READER_STATS_EN adds a stall_cycles counter port.
module banked_ram_stream_reader
    import stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_W     = 16,
    parameter int FIFO_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [COUNT_W-1:0]    cfg_num_words,
    output logic                  busy,
    output logic                  done,
    banked_ram_stream_reader_if.master bus
`ifdef STREAM_READER_STATS_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int OCC_W = FIFO_ADDR_W + 2;
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(1 << FIFO_ADDR_W);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [COUNT_W-1:0]    remaining;
    logic                  inflight;

    logic                  mem_req;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [FIFO_ADDR_W:0]  fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [OCC_W-1:0]      occ;
    logic                  last_pop;

    // Buffer space already promised: stored words plus the read in flight.
    assign occ = {1'b0, fifo_count} + {{(OCC_W-1){1'b0}}, inflight};

    assign mem_req = (state == STATE_ISSUE) && (remaining != '0)
                  && !fifo_full && (occ < DEPTH_V);

    assign bus.mem_read_req  = mem_req;
    assign bus.mem_read_addr = addr_q;
    assign bus.m_valid       = !fifo_empty;
    assign bus.m_data        = fifo_empty ? '0 : fifo_head;

    assign fifo_pop = !fifo_empty && bus.m_ready;
    assign last_pop = fifo_pop && !inflight
                   && (fifo_count == (FIFO_ADDR_W+1)'(1));

    stream_reader_fifo #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FIFO_ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (bus.mem_read_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // A read issued this cycle lands in the buffer next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= mem_req;
        end
    end

    // Transfer FSM with address/count registers and registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= STATE_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_q    <= '0;
            stride_q  <= '0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                STATE_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_num_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr_q    <= cfg_base_addr;
                            stride_q  <= cfg_stride;
                            remaining <= cfg_num_words;
                            busy      <= 1'b1;
                            state     <= STATE_ISSUE;
                        end
                    end
                end
                STATE_ISSUE: begin
                    if (mem_req) begin
                        addr_q    <= addr_q + stride_q;
                        remaining <= remaining - COUNT_W'(1);
                        if (remaining == COUNT_W'(1)) begin
                            state <= STATE_DRAIN;
                        end
                    end
                end
                STATE_DRAIN: begin
                    if (!inflight && (fifo_empty || last_pop)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= STATE_IDLE;
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STREAM_READER_STATS_EN
    // Saturating count of cycles the consumer stalls a busy transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (state == STATE_IDLE && cfg_start) begin
            stall_cycles <= '0;
        end else if (busy && !fifo_empty && !bus.m_ready
                     && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_banked_ram_stream_reader.sv
// Directed and randomized checks of banked_ram_stream_reader.
// Expected words come from a reference address/data list built from RAM contents.
module tb_banked_ram_stream_reader;

    localparam int AW    = 13;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int FAW   = 2;
    localparam int DEPTH = 1 << FAW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic [AW-1:0] cfg_base_addr;
    logic [AW-1:0] cfg_stride;
    logic [CW-1:0] cfg_num_words;
    logic          busy;
    logic          done;
`ifdef STREAM_READER_STATS_EN
    logic [31:0]   stall_cycles;
`endif

    logic [DW-1:0] ram [1 << AW];

    int tests = 0;
    int fails = 0;

    banked_ram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    banked_ram_stream_reader #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .COUNT_W     (CW),
        .FIFO_ADDR_W (FAW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_stride    (cfg_stride),
        .cfg_num_words (cfg_num_words),
        .busy          (busy),
        .done          (done),
        .bus           (bus)
`ifdef STREAM_READER_STATS_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle registered read.
    always @(posedge clk) begin
        if (bus.mem_read_req) begin
            bus.mem_read_data <= ram[bus.mem_read_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            1:       return ($urandom_range(0, 3) != 0);
            2:       return !(c >= 4 && c <= 12);
            3:       return !(c >= 3 && c <= 7);
            default: return 1'b1;
        endcase
    endfunction

    // One transfer: optional second start at restart_cyc, optional reset
    // after abort_after delivered words.
    task automatic run_xfer(input string name, input logic [AW-1:0] base,
                            input logic [AW-1:0] stride,
                            input logic [CW-1:0] num, input int mode,
                            input int restart_cyc, input int abort_after);
        logic [DW-1:0] exp_d[$];
        logic [AW-1:0] exp_a[$];
        logic [DW-1:0] got_d[$];
        logic [AW-1:0] got_a[$];
        int cyc, n_req, n_hs, max_out, first_v, last_hs, done_cyc;
        int extra;
        logic fin, busy_at_done, aborted;
        for (int i = 0; i < int'(num); i++) begin
            int a;
            a = (int'(base) + i * int'(stride)) % (1 << AW);
            exp_a.push_back(AW'(a));
            exp_d.push_back(ram[a]);
        end
        n_req = 0; n_hs = 0; max_out = 0; first_v = -1; last_hs = -1;
        done_cyc = -1; fin = 1'b0; busy_at_done = 1'bx; aborted = 1'b0;
        @(posedge clk); #1;
        cfg_base_addr = base;
        cfg_stride    = stride;
        cfg_num_words = num;
        cfg_start     = 1'b1;
        cyc = 0;
        bus.m_ready = rdy(mode, 0);
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            if (bus.mem_read_req) begin
                n_req++;
                got_a.push_back(bus.mem_read_addr);
                if (n_req - n_hs > max_out) max_out = n_req - n_hs;
            end
            if (bus.m_valid && bus.m_ready) begin
                got_d.push_back(bus.m_data);
                n_hs++;
                if (first_v < 0) first_v = cyc;
                last_hs = cyc;
            end
            if (done) begin
                fin = 1'b1;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (abort_after >= 0 && n_hs == abort_after) begin
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            cfg_start = (cyc == restart_cyc);
            if (cfg_start) begin
                cfg_base_addr = base ^ 13'h0100;
                cfg_num_words = 16'd3;
            end
            bus.m_ready = rdy(mode, cyc);
        end
        if (aborted) begin
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            bus.m_ready = 1'b1;
            @(negedge clk);
            check({name, " rst busy"}, 32'(busy), 0);
            check({name, " rst done"}, 32'(done), 0);
            check({name, " rst req"}, 32'(bus.mem_read_req), 0);
            check({name, " rst addr"}, 32'(bus.mem_read_addr), 0);
            check({name, " rst valid"}, 32'(bus.m_valid), 0);
            check({name, " rst data"}, 32'(bus.m_data), 0);
            extra = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (done || bus.m_valid || bus.mem_read_req) extra++;
            end
            check({name, " quiet after rst"}, 32'(extra), 0);
            return;
        end
        check({name, " timeout"}, 32'(fin), 1);
        cfg_start = 1'b0;
        bus.m_ready = 1'b1;
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || busy || bus.m_valid) extra++;
        end
        check({name, " idle after done"}, 32'(extra), 0);
        check({name, " busy at done"}, 32'(busy_at_done), 0);
        check({name, " word count"}, 32'(got_d.size()), 32'(num));
        check({name, " req count"}, 32'(got_a.size()), 32'(num));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++)
            check($sformatf("%s data[%0d]", name, i), 32'(got_d[i]),
                  32'(exp_d[i]));
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
            check($sformatf("%s addr[%0d]", name, i), 32'(got_a[i]),
                  32'(exp_a[i]));
        if (num == 0) begin
            check({name, " zero done cyc"}, 32'(done_cyc), 1);
        end else begin
            check({name, " first valid"}, 32'(first_v), 3);
            check({name, " done cyc"}, 32'(done_cyc), 32'(last_hs + 1));
            check({name, " credit"}, 32'(max_out <= DEPTH), 1);
            if (mode == 0)
                check({name, " back2back"}, 32'(last_hs - first_v),
                      32'(int'(num) - 1));
            if (mode == 2)
                check({name, " credit fill"}, 32'(max_out), DEPTH);
        end
    endtask

    initial begin
        reset = 1'b1;
        cfg_start = 1'b0;
        cfg_base_addr = '0;
        cfg_stride = '0;
        cfg_num_words = '0;
        bus.m_ready = 1'b1;
        for (int k = 0; k < (1 << AW); k++) ram[k] = DW'(k);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset req", 32'(bus.mem_read_req), 0);
        check("reset addr", 32'(bus.mem_read_addr), 0);
        check("reset valid", 32'(bus.m_valid), 0);
        check("reset data", 32'(bus.m_data), 0);

        run_xfer("basic", 13'h0010, 13'h0001, 16'd4, 0, -1, -1);
        run_xfer("wrap", 13'h1FFE, 13'h0800, 16'd3, 0, -1, -1);
        run_xfer("bp", 13'h0040, 13'h0003, 16'd10, 2, -1, -1);
        run_xfer("zero", 13'h0000, 13'h0001, 16'd0, 0, -1, -1);
        run_xfer("rebusy", 13'h0200, 13'h0002, 16'd6, 0, 2, -1);
        run_xfer("abort", 13'h0300, 13'h0001, 16'd8, 0, -1, 2);
        run_xfer("fresh", 13'h0500, 13'h0001, 16'd2, 0, -1, -1);

`ifdef STREAM_READER_STATS_EN
        run_xfer("stats", 13'h0600, 13'h0001, 16'd4, 3, -1, -1);
        check("stall count", stall_cycles, 32'd5);
        @(posedge clk); #1;
        cfg_num_words = '0;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        check("stall cleared", stall_cycles, 32'd0);
`endif

        for (int k = 0; k < (1 << AW); k++) ram[k] = DW'($urandom);
        for (int t = 0; t < 6; t++) begin
            run_xfer($sformatf("rand%0d", t), AW'($urandom),
                     AW'($urandom), CW'($urandom_range(1, 20)),
                     (t % 2 == 0) ? 1 : 0, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
